mips_muldiv_hilo: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS core. It consumes the two operands read from the register file (rs, rt) on MULT/MULTU/DIV/DIVU/MTHI/MTLO. It exposes HI/LO for MFHI/MFLO writeback into the register file. It asserts `busy` so the control FSM stalls HI/LO consumers until a result is ready.

---
 rtl/mips_muldiv_hilo_if.sv | 14 +
 rtl/mips_muldiv_hilo.sv | 134 +++++++++++++
 tb/tb_mips_muldiv_hilo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_hilo_if.sv
// Request/result bundle between the MIPS control path and the multiply/divide HI/LO unit.
interface mips_muldiv_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, op_a, op_b, input busy, done, hi, lo);
  modport slave  (input start, op, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_hilo.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO registers.
// Define MULDIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle one.
module mips_muldiv_hilo (
  input  logic                     clk,
  input  logic                     reset,
  mips_muldiv_hilo_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc;
  logic        is_div, neg_a, neg_b, div_zero;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        is_mul_op, is_div_op, go_calc, op_signed;
  logic [32:0] trial;
  logic [63:0] mul_step, prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign is_mul_op = (bus.op[2:1] == 2'b00);
  assign is_div_op = (bus.op[2:1] == 2'b01);
  assign op_signed = ~bus.op[0];

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod;
  assign go_calc = is_div_op;
  always_comb begin
    fast_prod = {32'b0, bus.op_a} * {32'b0, bus.op_b};
    if (op_signed)
      fast_prod = $unsigned($signed({{32{bus.op_a[31]}}, bus.op_a}) *
                            $signed({{32{bus.op_b[31]}}, bus.op_b}));
  end
`else
  assign go_calc = is_mul_op | is_div_op;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start && go_calc) state_next = CALC;
      CALC:    if (cnt == 5'd0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One step of each algorithm, MSB first: shift-add product, restoring-division trial subtract.
  always_comb begin
    trial    = {acc[63:32], a_mag[cnt]} - {1'b0, b_mag};
    mul_step = {acc[62:0], 1'b0} + (b_mag[cnt] ? {32'b0, a_mag} : 64'b0);
    prod_fix = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
    quot_fix = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix  = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
    if (div_zero)
      quot_fix = 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      a_mag    <= 32'd0;
      b_mag    <= 32'd0;
      acc      <= 64'd0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MTHI) hi_q <= bus.op_a;
            if (bus.op == OP_MTLO) lo_q <= bus.op_a;
            if (go_calc) begin
              neg_a    <= op_signed & bus.op_a[31];
              neg_b    <= op_signed & bus.op_b[31];
              a_mag    <= (op_signed && bus.op_a[31]) ? (32'd0 - bus.op_a) : bus.op_a;
              b_mag    <= (op_signed && bus.op_b[31]) ? (32'd0 - bus.op_b) : bus.op_b;
              div_zero <= (bus.op_b == 32'd0);
              is_div   <= bus.op[1];
              acc      <= 64'd0;
              cnt      <= 5'd31;
            end
`ifdef MULDIV_FAST_MULT_EN
            if (is_mul_op) begin
              {hi_q, lo_q} <= fast_prod;
              done_q       <= 1'b1;
            end
`endif
          end
        end
        CALC: begin
          cnt <= cnt - 5'd1;
          if (is_div) begin
            // A borrow means the divisor did not fit: keep the shifted remainder, quotient bit 0.
            acc[63:32] <= trial[32] ? {acc[62:32], a_mag[cnt]} : trial[31:0];
            acc[31:0]  <= {acc[30:0], ~trial[32]};
          end else begin
            acc <= mul_step;
          end
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_hilo.sv
// Randomized and directed self-checking bench for mips_muldiv_hilo against a plain-arithmetic HI/LO model.
module tb_mips_muldiv_hilo;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] r_hi, r_lo;
  int          r_lat, r_busy, r_early;
  logic        r_timeout, r_done_after;

  mips_muldiv_hilo_if bus ();

  mips_muldiv_hilo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hi,lo} straight from 64-bit integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
`ifdef MULDIV_FAST_MULT_EN
    return (op[2:1] == 2'b00) ? 0 : 33;
`else
    return (op[2:1] == 2'b00) ? 33 : 33;
`endif
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    r_lat = 0; r_busy = 0; r_early = 0;
    while (bus.done !== 1'b1 && r_lat < 100) begin
      if (bus.busy === 1'b1) r_busy++;
      if (bus.hi !== hi0 || bus.lo !== lo0) r_early++;
      @(posedge clk); #1;
      r_lat++;
    end
    r_timeout = (bus.done !== 1'b1);
    r_hi = bus.hi;
    r_lo = bus.lo;
    @(posedge clk); #1;
    r_done_after = bus.done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'd0)  begin errors++; $display("[TB] FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0)  begin errors++; $display("[TB] FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [6] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd3, 3'd2};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd7, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0};
    logic [31:0] elo [6] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i]);
      checks++; if (r_timeout !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_timeout got=%b exp=0", i, r_timeout); end
      checks++; if (r_hi !== ehi[i]) begin errors++; $display("[TB] FAIL dir%0d_hi got=%h exp=%h", i, r_hi, ehi[i]); end
      checks++; if (r_lo !== elo[i]) begin errors++; $display("[TB] FAIL dir%0d_lo got=%h exp=%h", i, r_lo, elo[i]); end
      checks++; if (r_lat !== exp_latency(ops[i])) begin errors++; $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, r_lat, exp_latency(ops[i])); end
      checks++; if (r_busy !== exp_latency(ops[i])) begin errors++; $display("[TB] FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, r_busy, exp_latency(ops[i])); end
      checks++; if (r_early !== 0) begin errors++; $display("[TB] FAIL dir%0d_hilo_hold got=%0d exp=0", i, r_early); end
      checks++; if (r_done_after !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_width got=%b exp=0", i, r_done_after); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      exp = ref_model(op, a, b);
      run_op(op, a, b);
      checks++; if (r_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_timeout got=%b exp=0", i, r_timeout); end
      checks++; if ({r_hi, r_lo} !== exp) begin errors++; $display("[TB] FAIL rnd%0d_hilo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, {r_hi, r_lo}, exp); end
      checks++; if (r_lat !== exp_latency(op)) begin errors++; $display("[TB] FAIL rnd%0d_latency got=%0d exp=%0d", i, r_lat, exp_latency(op)); end
    end
  endtask

  task automatic test_mthi_reset();
    int done_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.op_a = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mthi_hi got=%h exp=12345678", bus.hi); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mthi_done got=%b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.op_a = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.lo !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL mtlo_lo got=%h exp=0badf00d", bus.lo); end
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mtlo_hi_kept got=%h exp=12345678", bus.hi); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.op_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if ({bus.hi, bus.lo} !== 64'h1234_5678_0BAD_F00D) begin errors++; $display("[TB] FAIL nop_hilo got=%h exp=123456780badf00d", {bus.hi, bus.lo}); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.op_a = 32'd3; bus.op_b = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.hi, bus.lo} !== 64'd0) begin errors++; $display("[TB] FAIL abort_hilo got=%h exp=0", {bus.hi, bus.lo}); end
    done_seen = 0;
    repeat (40) begin
      if (bus.done !== 1'b0) done_seen++;
      @(posedge clk); #1;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_seen); end
    checks++; if ({bus.hi, bus.lo} !== 64'd0) begin errors++; $display("[TB] FAIL abort_hilo_late got=%h exp=0", {bus.hi, bus.lo}); end
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 3'b100; bus.op_a = 32'h5555_5555;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_beats_start got=%h exp=0", bus.hi); end
  endtask

  task automatic test_ignore_and_back_to_back();
    logic [63:0] exp1, exp2;
    int n;
    exp1 = ref_model(3'd2, 32'hFFFF_FF9C, 32'd7);
    exp2 = ref_model(3'd3, 32'd9, 32'd2);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.op_a = 32'hFFFF_FF9C; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.op_a = 32'h0000_AAAA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_timeout got=%b exp=1", bus.done); end
    checks++; if ({bus.hi, bus.lo} !== exp1) begin errors++; $display("[TB] FAIL ignore_div_result got=%h exp=%h", {bus.hi, bus.lo}, exp1); end
    checks++; if (n !== 33 - 9) begin errors++; $display("[TB] FAIL ignore_latency got=%0d exp=%0d", n, 33 - 9); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b011; bus.op_a = 32'd9; bus.op_b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL done_cycle_accept_busy got=%b exp=1", bus.busy); end
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_timeout got=%b exp=1", bus.done); end
    checks++; if ({bus.hi, bus.lo} !== exp2) begin errors++; $display("[TB] FAIL b2b_result got=%h exp=%h", {bus.hi, bus.lo}, exp2); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.op_a  = 32'd0;
    bus.op_b  = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_mthi_reset();
    test_ignore_and_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
